sgd_gradient_seq: RTL and testbench

Sequencer for the bit-serial gradient datapath. It walks epochs and samples, accepts one dot-product result per sample, and issues exactly chunks × number_of_bits reads from the A-FIFO for that sample. It stalls on FIFO-empty and tags each beat with its bit and chunk index. It sits between the dot-product engine and the gradient accumulator, and replaces free-running read generation with a flow-controlled schedule.

---
 rtl/sgd_seq_pkg.sv | 10 +
 rtl/sgd_seq_beat_ctr.sv | 28 ++
 rtl/sgd_gradient_seq.sv | 120 ++++++++++++
 tb/tb_sgd_gradient_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sgd_seq_pkg.sv
// sgd_seq_pkg: shared state encoding, default widths and precision clamp for the gradient sequencer
package sgd_seq_pkg;
  localparam int SEQ_DIM_SHIFT = 9;
  localparam int SEQ_CHUNK_W = 12;
  localparam int SEQ_BIT_W = 5;
  typedef enum logic [2:0] {IDLE, CFG, WAIT_DOT, STREAM, SAMPLE_END, DONE} seq_state_e;
  function automatic logic [5:0] clamp_bits(input logic [5:0] n);
    return n == 6'd0 ? 6'd1 : n > 6'd32 ? 6'd32 : n;
  endfunction
endpackage

// File: rtl/sgd_seq_beat_ctr.sv
// sgd_seq_beat_ctr: nested bit/chunk beat counter with load, enable and end-of-sample flag
module sgd_seq_beat_ctr import sgd_seq_pkg::*; #(
  parameter int CHUNK_W = SEQ_CHUNK_W,
  parameter int BIT_W = SEQ_BIT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [5:0]         bits,
  input  logic [CHUNK_W-1:0] chunks,
  output logic [BIT_W-1:0]   bit_idx,
  output logic [CHUNK_W-1:0] chunk_idx,
  output logic               last_bit,
  output logic               last
);
  assign last_bit = bit_idx == BIT_W'(bits - 6'd1);
  assign last = last_bit && chunk_idx == chunks - CHUNK_W'(1);
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      bit_idx <= '0;
      chunk_idx <= '0;
    end else if (en) begin
      bit_idx <= last_bit ? '0 : bit_idx + BIT_W'(1);
      chunk_idx <= last_bit ? chunk_idx + CHUNK_W'(1) : chunk_idx;
    end
  end
endmodule

// File: rtl/sgd_gradient_seq.sv
// sgd_gradient_seq: epoch/sample sequencer issuing chunks x bits flow-controlled A-FIFO reads per dot result
// Optional stall counter built when SGD_GRAD_SEQ_STALL_CNT_EN is defined.
module sgd_gradient_seq import sgd_seq_pkg::*; #(
  parameter int DIM_SHIFT = SEQ_DIM_SHIFT,
  parameter int CHUNK_W = SEQ_CHUNK_W,
  parameter int BIT_W = SEQ_BIT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               started,
  input  logic [31:0]        number_of_epochs,
  input  logic [31:0]        number_of_samples,
  input  logic [31:0]        dimension,
  input  logic [31:0]        number_of_bits,
  input  logic               fifo_a_empty,
  output logic               fifo_a_rd_en,
  input  logic               dot_valid,
  output logic               dot_ready,
  output logic               beat_first,
  output logic               beat_last_bit,
  output logic [BIT_W-1:0]   bit_index,
  output logic [CHUNK_W-1:0] chunk_index,
  output logic               sample_done,
  output logic               epoch_done,
  output logic               all_done,
  output logic               busy,
  output logic [31:0]        stall_cycles
);
  seq_state_e state;
  logic started_q, beat_last, beat_last_b, last_sample, last_epoch, enter_end;
  logic [CHUNK_W-1:0] chunks;
  logic [5:0] bits;
  logic [31:0] epochs, samples, sample_cnt, epoch_cnt;
  logic unused_bits;
  assign unused_bits = ^number_of_bits[31:6];
  assign fifo_a_rd_en = rst_n && state == STREAM && !fifo_a_empty;
  assign beat_first = state == STREAM && bit_index == '0 && chunk_index == '0;
  assign beat_last_bit = state == STREAM && beat_last_b;
  assign last_sample = sample_cnt == samples - 32'd1;
  assign last_epoch = epoch_cnt == epochs - 32'd1;
  assign enter_end = (state == WAIT_DOT && dot_valid && chunks == '0) || (fifo_a_rd_en && beat_last);
  sgd_seq_beat_ctr #(.CHUNK_W(CHUNK_W), .BIT_W(BIT_W)) u_beat (
    .clk(clk), .rst_n(rst_n), .load(state == CFG || state == WAIT_DOT), .en(fifo_a_rd_en),
    .bits(bits), .chunks(chunks), .bit_idx(bit_index), .chunk_idx(chunk_index),
    .last_bit(beat_last_b), .last(beat_last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      started_q <= 1'b0;
      dot_ready <= 1'b0;
      sample_done <= 1'b0;
      epoch_done <= 1'b0;
      all_done <= 1'b0;
      busy <= 1'b0;
      chunks <= '0;
      bits <= '0;
      epochs <= '0;
      samples <= '0;
      sample_cnt <= '0;
      epoch_cnt <= '0;
    end else begin
      started_q <= started;
      sample_done <= enter_end;
      epoch_done <= enter_end && last_sample;
      case (state)
        IDLE: if (started && !started_q) begin
          state <= CFG;
          busy <= 1'b1;
        end
        CFG: begin
          chunks <= CHUNK_W'((dimension >> DIM_SHIFT) + 32'(|dimension[DIM_SHIFT-1:0]));
          bits <= clamp_bits(number_of_bits[5:0]);
          epochs <= number_of_epochs;
          samples <= number_of_samples;
          sample_cnt <= '0;
          epoch_cnt <= '0;
          if (number_of_epochs == '0 || number_of_samples == '0) begin
            state <= DONE;
            all_done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= WAIT_DOT;
            dot_ready <= 1'b1;
          end
        end
        WAIT_DOT: if (dot_valid) begin
          dot_ready <= 1'b0;
          state <= chunks != '0 ? STREAM : SAMPLE_END;
        end
        STREAM: if (fifo_a_rd_en && beat_last) state <= SAMPLE_END;
        SAMPLE_END: begin
          sample_cnt <= last_sample ? '0 : sample_cnt + 32'd1;
          epoch_cnt <= last_sample ? epoch_cnt + 32'd1 : epoch_cnt;
          if (last_sample && last_epoch) begin
            state <= DONE;
            all_done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= WAIT_DOT;
            dot_ready <= 1'b1;
          end
        end
        DONE: if (!started) begin
          state <= IDLE;
          all_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SGD_GRAD_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || state == CFG) stall_cycles <= '0;
    else if (state == STREAM && fifo_a_empty && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_sgd_gradient_seq.sv
// tb_sgd_gradient_seq: randomized bench checking the sequencer against a beat-queue reference model
module tb_sgd_gradient_seq;
  logic clk = 1'b0;
  logic rst_n, started, fifo_a_empty, fifo_a_rd_en, dot_valid, dot_ready;
  logic beat_first, beat_last_bit, sample_done, epoch_done, all_done, busy;
  logic [31:0] number_of_epochs, number_of_samples, dimension, number_of_bits, stall_cycles;
  logic [4:0] bit_index;
  logic [11:0] chunk_index;
  int vectors = 0, errors = 0;
`ifdef SGD_GRAD_SEQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  typedef struct {int b; int c;} beat_t;
  always #5 clk = ~clk;
  sgd_gradient_seq dut (
    .clk(clk), .rst_n(rst_n), .started(started), .number_of_epochs(number_of_epochs),
    .number_of_samples(number_of_samples), .dimension(dimension), .number_of_bits(number_of_bits),
    .fifo_a_empty(fifo_a_empty), .fifo_a_rd_en(fifo_a_rd_en), .dot_valid(dot_valid),
    .dot_ready(dot_ready), .beat_first(beat_first), .beat_last_bit(beat_last_bit),
    .bit_index(bit_index), .chunk_index(chunk_index), .sample_done(sample_done),
    .epoch_done(epoch_done), .all_done(all_done), .busy(busy), .stall_cycles(stall_cycles)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({fifo_a_rd_en, dot_ready, beat_first, beat_last_bit, bit_index, chunk_index,
                sample_done, epoch_done, all_done, busy, stall_cycles});
  endfunction
  // mode 0: FIFO never empty; 1: random empties and started dropped mid-run; 2: 5-cycle gap after 3rd pop
  task automatic run(input logic [31:0] ep, input logic [31:0] sp, input logic [31:0] dim,
                     input logic [31:0] nb, input int mode);
    int chunks, bits, total, accepted, sdone, edone, stall, pops, gap, done_cyc;
    bit done;
    beat_t q[$];
    chunks = int'(((longint'(dim) + 511) / 512) % 4096);
    bits = nb[5:0] == 0 ? 1 : nb[5:0] > 32 ? 32 : int'(nb[5:0]);
    total = int'(ep) * int'(sp);
    accepted = 0; sdone = 0; edone = 0; stall = 0; pops = 0; gap = 0; done = 0; done_cyc = -1;
    number_of_epochs = ep; number_of_samples = sp; dimension = dim; number_of_bits = nb;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clk); #1;
      started = mode == 1 ? cyc < 3 : 1'b1;
      fifo_a_empty = gap > 0 ? 1'b1 : mode == 1 ? $urandom_range(0, 2) == 0 : 1'b0;
      if (gap > 0) gap--;
      dot_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rd_en", fifo_a_rd_en, q.size() > 0 && !fifo_a_empty);
      check("dot_ready_idle", dot_ready && (q.size() > 0 || accepted >= total), 0);
      if (q.size() > 0) begin
        check("bit_index", bit_index, q[0].b);
        check("chunk_index", chunk_index, q[0].c);
        if (fifo_a_empty) stall++;
        if (fifo_a_rd_en) begin
          check("beat_first", beat_first, q[0].b == 0 && q[0].c == 0);
          check("beat_last_bit", beat_last_bit, q[0].b == bits - 1);
          void'(q.pop_front());
          pops++;
          if (mode == 2 && pops == 3) gap = 5;
        end
      end
      if (dot_ready && dot_valid && accepted < total) begin
        accepted++;
        for (int c = 0; c < chunks; c++)
          for (int b = 0; b < bits; b++) q.push_back('{b, c});
      end
      sdone += int'(sample_done);
      edone += int'(epoch_done);
      if (all_done) begin
        done = 1;
        done_cyc = cyc;
      end
    end
    check("all_done", done, 1);
    check("accepted", accepted, total);
    check("beats_left", q.size(), 0);
    check("sample_done_cnt", sdone, total);
    check("epoch_done_cnt", edone, total == 0 ? 0 : int'(ep));
    check("busy_at_done", busy, 0);
    check("stall_cycles", stall_cycles, STALL_EN ? stall : 0);
    if (total == 0) check("done_latency", done_cyc, 2);
    if (mode == 2) check("stall_gap", stall_cycles, STALL_EN ? 5 : 0);
    if (mode != 1) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("done_hold", all_done, 1);
    end
    @(posedge clk); #1;
    started = 0; dot_valid = 0; fifo_a_empty = 0;
    repeat (2) @(negedge clk);
    check("done_clear", {all_done, busy}, 0);
  endtask
  initial begin
    int pops;
    rst_n = 0; started = 0; fifo_a_empty = 0; dot_valid = 0;
    number_of_epochs = 0; number_of_samples = 0; dimension = 0; number_of_bits = 0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 0);
    @(posedge clk); #1 rst_n = 1;
    run(1, 2, 1024, 4, 0);
    run(1, 2, 513, 1, 0);
    run(2, 2, 0, 4, 0);
    run(0, 3, 1024, 4, 0);
    run(2, 0, 1024, 4, 0);
    run(1, 2, 1024, 4, 2);
    run(2, 2, 512, 40, 0);
    run(1, 2, 1024, 0, 1);
    run(1, 2, 32'hFFFF_FFFF, 7, 1);
    number_of_epochs = 1; number_of_samples = 2; dimension = 1024; number_of_bits = 4;
    fifo_a_empty = 0; dot_valid = 1;
    @(posedge clk); #1 started = 1;
    pops = 0;
    for (int i = 0; i < 50 && pops < 3; i++) begin
      @(negedge clk);
      pops += int'(fifo_a_rd_en);
    end
    check("pre_reset_pops", pops, 3);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    check("reset_no_pop", fifo_a_rd_en, 0);
    @(posedge clk); #1 started = 0; dot_valid = 0;
    @(negedge clk);
    check("midrun_reset_outs", outs(), 0);
    @(posedge clk); #1 rst_n = 1;
    run(1, 2, 1024, 4, 0);
    for (int i = 0; i < 6; i++)
      run($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2000), $urandom_range(0, 63),
          int'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
